// File: rtl/table_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : table_arb_pkg
// Description : Shared sizing defaults and response-map type for table_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package table_arb_pkg;

    localparam int NUM_CLIENTS_DEF = 4;
    localparam int TABLE_SIZE_DEF  = 32;
    localparam int DATA_WIDTH_DEF  = 8;
    localparam int INPUT_RATE_DEF  = 2;
    localparam int OUTPUT_RATE_DEF = 2;
    localparam int IW_DEF          = $clog2(TABLE_SIZE_DEF);
    localparam int CLIENT_W        = $clog2(NUM_CLIENTS_DEF);

    typedef struct packed {
        logic                valid;
        logic [CLIENT_W-1:0] client;
    } lane_map_t;

    // Client id successor, wrapping at n (n need not be a power of two).
    function automatic logic [CLIENT_W-1:0] wrap_inc(input logic [CLIENT_W-1:0] c,
                                                     input int n);
        return ((int'(c) + 1) >= n) ? '0 : c + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/table_arb_lane_alloc.sv
`default_nettype none
// ============================================================================
// Module      : table_arb_lane_alloc
// Description : Combinational rotate-scan allocator of write/read table lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module table_arb_lane_alloc
    import table_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = NUM_CLIENTS_DEF,
    parameter int IW          = IW_DEF,
    parameter int INPUT_RATE  = INPUT_RATE_DEF,
    parameter int OUTPUT_RATE = OUTPUT_RATE_DEF,
    parameter int CW          = CLIENT_W
) (
    input  logic [CW-1:0]               ptr_i,
    input  logic [NUM_CLIENTS-1:0]      req_valid_i,
    input  logic [NUM_CLIENTS-1:0]      req_write_i,
    input  logic [NUM_CLIENTS*IW-1:0]   req_index_i,
    output logic [NUM_CLIENTS-1:0]      grant_o,
    output logic [INPUT_RATE-1:0]       wr_vld_o,
    output logic [INPUT_RATE*CW-1:0]    wr_client_o,
    output logic [OUTPUT_RATE-1:0]      rd_vld_o,
    output logic [OUTPUT_RATE*CW-1:0]   rd_client_o,
    output logic                        any_grant_o,
    output logic [CW-1:0]               last_client_o
);

    localparam int NC = NUM_CLIENTS;

    // Requests rotated so that scan position 0 is the client at ptr_i.
    logic [2*NC-1:0]    w_rot_vld;
    logic [2*NC-1:0]    w_rot_wr;
    logic [2*NC*IW-1:0] w_rot_idx;
    logic [NC-1:0]      w_rot_gnt;
    logic [2*NC-1:0]    w_gnt_unrot;
    logic [INPUT_RATE*IW-1:0] w_lane_idx;

    assign w_rot_vld = {req_valid_i, req_valid_i} >> ptr_i;
    assign w_rot_wr  = {req_write_i, req_write_i} >> ptr_i;
    assign w_rot_idx = {req_index_i, req_index_i} >> (ptr_i * IW);

    always_comb begin
        int             wr_cnt;
        int             rd_cnt;
        int             cl;
        logic           clash;
        logic [IW-1:0]  cur_idx;
        w_rot_gnt     = '0;
        wr_vld_o      = '0;
        wr_client_o   = '0;
        rd_vld_o      = '0;
        rd_client_o   = '0;
        w_lane_idx    = '0;
        any_grant_o   = 1'b0;
        last_client_o = '0;
        wr_cnt        = 0;
        rd_cnt        = 0;
        for (int s = 0; s < NC; s++) begin
            cl = int'(ptr_i) + s;
            if (cl >= NC) cl = cl - NC;
            cur_idx = w_rot_idx[s*IW +: IW];
            clash   = 1'b0;
            for (int k = 0; k < INPUT_RATE; k++) begin
                if (k < wr_cnt && w_lane_idx[k*IW +: IW] == cur_idx) clash = 1'b1;
            end
            if (w_rot_vld[s] && w_rot_wr[s] && !clash && wr_cnt < INPUT_RATE) begin
                for (int k = 0; k < INPUT_RATE; k++) begin
                    if (k == wr_cnt) begin
                        wr_vld_o[k]              = 1'b1;
                        wr_client_o[k*CW +: CW]  = CW'(cl);
                        w_lane_idx[k*IW +: IW]   = cur_idx;
                    end
                end
                wr_cnt        = wr_cnt + 1;
                w_rot_gnt[s]  = 1'b1;
                any_grant_o   = 1'b1;
                last_client_o = CW'(cl);
            end else if (w_rot_vld[s] && !w_rot_wr[s] && rd_cnt < OUTPUT_RATE) begin
                for (int k = 0; k < OUTPUT_RATE; k++) begin
                    if (k == rd_cnt) begin
                        rd_vld_o[k]             = 1'b1;
                        rd_client_o[k*CW +: CW] = CW'(cl);
                    end
                end
                rd_cnt        = rd_cnt + 1;
                w_rot_gnt[s]  = 1'b1;
                any_grant_o   = 1'b1;
                last_client_o = CW'(cl);
            end
        end
    end

    assign w_gnt_unrot = {w_rot_gnt, w_rot_gnt} << ptr_i;
    assign grant_o     = w_gnt_unrot[2*NC-1:NC];

endmodule
`default_nettype wire

// File: rtl/table_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : table_arbiter
// Description : Round-robin front-end sharing one multi-lane table among clients.
// Revision    : 1.0 - initial release
// ============================================================================
module table_arbiter
    import table_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = NUM_CLIENTS_DEF,
    parameter int TABLE_SIZE  = TABLE_SIZE_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int INPUT_RATE  = INPUT_RATE_DEF,
    parameter int OUTPUT_RATE = OUTPUT_RATE_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_CLIENTS-1:0]              req_valid,
    input  logic [NUM_CLIENTS-1:0]              req_write,
    input  logic [NUM_CLIENTS*$clog2(TABLE_SIZE)-1:0] req_index,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_CLIENTS-1:0]              req_ready,
    output logic [NUM_CLIENTS-1:0]              rsp_valid,
    output logic [NUM_CLIENTS*DATA_WIDTH-1:0]   rsp_data,
    output logic                                tbl_wr_en,
    output logic                                tbl_rd_en,
    output logic [INPUT_RATE*$clog2(TABLE_SIZE)-1:0]  tbl_index_wr,
    output logic [OUTPUT_RATE*$clog2(TABLE_SIZE)-1:0] tbl_index_rd,
    output logic [INPUT_RATE*DATA_WIDTH-1:0]    tbl_data_wr,
    input  logic [OUTPUT_RATE*DATA_WIDTH-1:0]   tbl_data_rd
);

    localparam int IW = $clog2(TABLE_SIZE);
    localparam int CW = CLIENT_W;
    localparam int DW = DATA_WIDTH;

    logic [CW-1:0]                 ptr_q;
    logic [CW-1:0]                 ptr_d;
    lane_map_t [OUTPUT_RATE-1:0]   map_q;
    lane_map_t [OUTPUT_RATE-1:0]   map_d;

    logic [NUM_CLIENTS-1:0]        w_grant;
    logic [INPUT_RATE-1:0]         w_wr_vld;
    logic [INPUT_RATE*CW-1:0]      w_wr_client;
    logic [OUTPUT_RATE-1:0]        w_rd_vld;
    logic [OUTPUT_RATE*CW-1:0]     w_rd_client;
    logic                          w_any_grant;
    logic [CW-1:0]                 w_last_client;

    table_arb_lane_alloc #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IW          (IW),
        .INPUT_RATE  (INPUT_RATE),
        .OUTPUT_RATE (OUTPUT_RATE),
        .CW          (CW)
    ) u_alloc (
        .ptr_i         (ptr_q),
        .req_valid_i   (req_valid),
        .req_write_i   (req_write),
        .req_index_i   (req_index),
        .grant_o       (w_grant),
        .wr_vld_o      (w_wr_vld),
        .wr_client_o   (w_wr_client),
        .rd_vld_o      (w_rd_vld),
        .rd_client_o   (w_rd_client),
        .any_grant_o   (w_any_grant),
        .last_client_o (w_last_client)
    );

    // Every table-facing output is forced quiet while reset is held.
    assign req_ready = w_grant & {NUM_CLIENTS{rst}};
    assign tbl_wr_en = rst & (|w_wr_vld);
    assign tbl_rd_en = rst & (|w_rd_vld);

    assign ptr_d = w_any_grant ? wrap_inc(w_last_client, NUM_CLIENTS) : ptr_q;

    always_comb begin
        map_d = '0;
        for (int l = 0; l < OUTPUT_RATE; l++) begin
            map_d[l].valid  = w_rd_vld[l];
            map_d[l].client = w_rd_client[l*CW +: CW];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            map_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            map_q <= map_d;
        end
    end

    // Unused write lanes copy lane 0 so the table's all-lane write stays benign.
    always_comb begin
        logic [CW-1:0] w_src;
        tbl_index_wr = '0;
        tbl_data_wr  = '0;
        tbl_index_rd = '0;
        for (int k = 0; k < INPUT_RATE; k++) begin
            w_src = w_wr_vld[k] ? w_wr_client[k*CW +: CW] : w_wr_client[CW-1:0];
            for (int c = 0; c < NUM_CLIENTS; c++) begin
                if (tbl_wr_en && w_src == CW'(c)) begin
                    tbl_index_wr[k*IW +: IW] = req_index[c*IW +: IW];
                    tbl_data_wr[k*DW +: DW]  = req_wdata[c*DW +: DW];
                end
            end
        end
        for (int k = 0; k < OUTPUT_RATE; k++) begin
            for (int c = 0; c < NUM_CLIENTS; c++) begin
                if (rst && w_rd_vld[k] && w_rd_client[k*CW +: CW] == CW'(c)) begin
                    tbl_index_rd[k*IW +: IW] = req_index[c*IW +: IW];
                end
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        for (int c = 0; c < NUM_CLIENTS; c++) begin
            for (int l = 0; l < OUTPUT_RATE; l++) begin
                if (map_q[l].valid && map_q[l].client == CW'(c)) begin
                    rsp_valid[c]          = 1'b1;
                    rsp_data[c*DW +: DW]  = tbl_data_rd[l*DW +: DW];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_table_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_table_arbiter
// Description : Self-checking bench for table_arbiter with table and arbitration model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_table_arbiter;

    localparam int NC  = 4;
    localparam int TS  = 32;
    localparam int DW  = 8;
    localparam int WRL = 2;
    localparam int RDL = 2;
    localparam int IW  = 5;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NC-1:0]       req_valid = '0;
    logic [NC-1:0]       req_write = '0;
    logic [NC*IW-1:0]    req_index = '0;
    logic [NC*DW-1:0]    req_wdata = '0;
    logic [NC-1:0]       req_ready;
    logic [NC-1:0]       rsp_valid;
    logic [NC*DW-1:0]    rsp_data;
    logic                tbl_wr_en;
    logic                tbl_rd_en;
    logic [WRL*IW-1:0]   tbl_index_wr;
    logic [RDL*IW-1:0]   tbl_index_rd;
    logic [WRL*DW-1:0]   tbl_data_wr;
    logic [RDL*DW-1:0]   tbl_data_rd;

    always #5 clk = ~clk;

    table_arbiter #(
        .NUM_CLIENTS (NC),
        .TABLE_SIZE  (TS),
        .DATA_WIDTH  (DW),
        .INPUT_RATE  (WRL),
        .OUTPUT_RATE (RDL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_index    (req_index),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .tbl_wr_en    (tbl_wr_en),
        .tbl_rd_en    (tbl_rd_en),
        .tbl_index_wr (tbl_index_wr),
        .tbl_index_rd (tbl_index_rd),
        .tbl_data_wr  (tbl_data_wr),
        .tbl_data_rd  (tbl_data_rd)
    );

    // The shared table: all-lane write, registered read returning pre-write data.
    logic [DW-1:0] mem [TS] = '{default: '0};
    always @(posedge clk) begin
        if (tbl_wr_en)
            for (int k = 0; k < WRL; k++) mem[tbl_index_wr[k*IW +: IW]] <= tbl_data_wr[k*DW +: DW];
        if (tbl_rd_en)
            for (int k = 0; k < RDL; k++) tbl_data_rd[k*DW +: DW] <= mem[tbl_index_rd[k*IW +: IW]];
    end

    typedef struct {
        logic [NC-1:0]    v;
        logic [NC-1:0]    w;
        logic [NC*IW-1:0] idx;
        logic [NC*DW-1:0] wd;
        logic [NC-1:0]    rdy;
        logic [NC-1:0]    rv;
        logic [NC*DW-1:0] rd;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    logic [DW-1:0]    gold [TS] = '{default: '0};
    int               m_ptr = 0;
    int               m_wq[$];
    int               m_rq[$];
    int               m_last;
    logic [NC-1:0]    m_rdy;
    logic [NC-1:0]    m_pv = '0;
    logic [NC*DW-1:0] m_pd = '0;

    function automatic logic [NC*IW-1:0] pi(input int a, input int b, input int c, input int d);
        return {IW'(d), IW'(c), IW'(b), IW'(a)};
    endfunction

    function automatic logic [IW-1:0] idx_of(input logic [NC*IW-1:0] b, input int c);
        return b[c*IW +: IW];
    endfunction

    function automatic logic [DW-1:0] dat_of(input logic [NC*DW-1:0] b, input int c);
        return b[c*DW +: DW];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scan clients from ptr; writes and reads fill their own lanes in scan order.
    task automatic model_arb(input vec_t t);
        int  c;
        bit  clash;
        m_wq.delete();
        m_rq.delete();
        m_rdy  = '0;
        m_last = -1;
        for (int s = 0; s < NC; s++) begin
            c = (m_ptr + s) % NC;
            if (t.v[c]) begin
                if (t.w[c]) begin
                    clash = 0;
                    foreach (m_wq[j]) if (idx_of(t.idx, m_wq[j]) == idx_of(t.idx, c)) clash = 1;
                    if (m_wq.size() < WRL && !clash) begin
                        m_wq.push_back(c); m_rdy[c] = 1'b1; m_last = c;
                    end
                end else if (m_rq.size() < RDL) begin
                    m_rq.push_back(c); m_rdy[c] = 1'b1; m_last = c;
                end
            end
        end
    endtask

    task automatic run_cycle(input vec_t t, input bit hand, input int tag);
        logic [WRL*IW-1:0] ewi;
        logic [WRL*DW-1:0] ewd;
        logic [RDL*IW-1:0] eri;
        int                src;
        @(negedge clk);
        req_valid = t.v;
        req_write = t.w;
        req_index = t.idx;
        req_wdata = t.wd;
        #1;
        model_arb(t);
        ewi = '0; ewd = '0; eri = '0;
        for (int k = 0; k < WRL; k++) begin
            if (m_wq.size() > 0) begin
                src = (k < m_wq.size()) ? m_wq[k] : m_wq[0];
                ewi[k*IW +: IW] = idx_of(t.idx, src);
                ewd[k*DW +: DW] = dat_of(t.wd, src);
            end
        end
        for (int k = 0; k < RDL; k++)
            if (k < m_rq.size()) eri[k*IW +: IW] = idx_of(t.idx, m_rq[k]);
        chk($sformatf("c%0d_ready", tag),     64'(req_ready),    64'(m_rdy));
        chk($sformatf("c%0d_wr_en", tag),     64'(tbl_wr_en),    64'(m_wq.size() > 0));
        chk($sformatf("c%0d_rd_en", tag),     64'(tbl_rd_en),    64'(m_rq.size() > 0));
        chk($sformatf("c%0d_idx_wr", tag),    64'(tbl_index_wr), 64'(ewi));
        chk($sformatf("c%0d_data_wr", tag),   64'(tbl_data_wr),  64'(ewd));
        chk($sformatf("c%0d_idx_rd", tag),    64'(tbl_index_rd), 64'(eri));
        chk($sformatf("c%0d_rsp_valid", tag), 64'(rsp_valid),    64'(m_pv));
        chk($sformatf("c%0d_rsp_data", tag),  64'(rsp_data),     64'(m_pd));
        if (hand) begin
            chk($sformatf("vec%0d_ready", tag),     64'(req_ready), 64'(t.rdy));
            chk($sformatf("vec%0d_rsp_valid", tag), 64'(rsp_valid), 64'(t.rv));
            chk($sformatf("vec%0d_rsp_data", tag),  64'(rsp_data),  64'(t.rd));
        end
        @(posedge clk);
        m_pv = '0;
        m_pd = '0;
        foreach (m_rq[j]) begin
            m_pv[m_rq[j]] = 1'b1;
            m_pd[m_rq[j]*DW +: DW] = gold[idx_of(t.idx, m_rq[j])];
        end
        foreach (m_wq[j]) gold[idx_of(t.idx, m_wq[j])] = dat_of(t.wd, m_wq[j]);
        if (m_last >= 0) m_ptr = (m_last + 1) % NC;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_ready"},  64'(req_ready),    64'd0);
        chk({name, "_en"},     64'({tbl_wr_en, tbl_rd_en}), 64'd0);
        chk({name, "_buses"},  64'({tbl_index_wr, tbl_index_rd, tbl_data_wr}), 64'd0);
        chk({name, "_rsp_v"},  64'(rsp_valid),    64'd0);
        chk({name, "_rsp_d"},  64'(rsp_data),     64'd0);
    endtask

    vec_t vecs[19];
    vec_t t;

    initial begin
        vecs[0]  = '{4'b1111, 4'b1111, pi(1,2,3,4), 32'hA4A3A2A1, 4'b0011, 4'b0000, 32'h0};
        vecs[1]  = '{4'b1100, 4'b1100, pi(1,2,3,4), 32'hA4A3A2A1, 4'b1100, 4'b0000, 32'h0};
        vecs[2]  = '{4'b1111, 4'b0000, pi(1,2,3,4), 32'h0,        4'b0011, 4'b0000, 32'h0};
        vecs[3]  = '{4'b1100, 4'b0000, pi(1,2,3,4), 32'h0,        4'b1100, 4'b0011, 32'h0000A2A1};
        vecs[4]  = '{4'b0000, 4'b0000, pi(0,0,0,0), 32'h0,        4'b0000, 4'b1100, 32'hA4A30000};
        vecs[5]  = '{4'b0011, 4'b0011, pi(5,5,0,0), 32'h00002211, 4'b0001, 4'b0000, 32'h0};
        vecs[6]  = '{4'b0010, 4'b0010, pi(5,5,0,0), 32'h00002211, 4'b0010, 4'b0000, 32'h0};
        vecs[7]  = '{4'b0001, 4'b0000, pi(5,0,0,0), 32'h0,        4'b0001, 4'b0000, 32'h0};
        vecs[8]  = '{4'b0000, 4'b0000, pi(0,0,0,0), 32'h0,        4'b0000, 4'b0001, 32'h00000022};
        vecs[9]  = '{4'b1111, 4'b0010, pi(1,9,2,3), 32'h00003300, 4'b1110, 4'b0000, 32'h0};
        vecs[10] = '{4'b0001, 4'b0000, pi(1,9,2,3), 32'h0,        4'b0001, 4'b1100, 32'hA3A20000};
        vecs[11] = '{4'b1000, 4'b0000, pi(0,0,0,9), 32'h0,        4'b1000, 4'b0001, 32'h000000A1};
        vecs[12] = '{4'b1111, 4'b0000, pi(1,2,3,4), 32'h0,        4'b0011, 4'b1000, 32'h33000000};
        vecs[13] = '{4'b1111, 4'b0000, pi(1,2,3,4), 32'h0,        4'b1100, 4'b0011, 32'h0000A2A1};
        vecs[14] = '{4'b1111, 4'b0000, pi(1,2,3,4), 32'h0,        4'b0011, 4'b1100, 32'hA4A30000};
        vecs[15] = '{4'b0000, 4'b0000, pi(0,0,0,0), 32'h0,        4'b0000, 4'b0011, 32'h0000A2A1};
        vecs[16] = '{4'b0011, 4'b0001, pi(7,7,0,0), 32'h0000005A, 4'b0011, 4'b0000, 32'h0};
        vecs[17] = '{4'b0010, 4'b0000, pi(7,7,0,0), 32'h0,        4'b0010, 4'b0010, 32'h0};
        vecs[18] = '{4'b0000, 4'b0000, pi(0,0,0,0), 32'h0,        4'b0000, 4'b0010, 32'h00005A00};

        // Reset held with live requests: everything quiet.
        req_valid = 4'b1111;
        req_write = 4'b0101;
        req_index = pi(1,2,3,4);
        repeat (2) @(negedge clk);
        #1;
        chk_quiet("reset");
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;

        for (int i = 0; i < 19; i++) run_cycle(vecs[i], 1'b1, i);

        // Random traffic on indices 8..15 leaves the directed data intact.
        for (int i = 0; i < 400; i++) begin
            t.v = 4'($urandom_range(0, 15));
            t.w = 4'($urandom_range(0, 15));
            t.idx = pi($urandom_range(8, 15), $urandom_range(8, 15),
                       $urandom_range(8, 15), $urandom_range(8, 15));
            t.wd = $urandom;
            t.rdy = '0; t.rv = '0; t.rd = '0;
            run_cycle(t, 1'b0, 100 + i);
        end

        // Two reads in flight, then reset on the cycle their data would appear.
        t = '{4'b0011, 4'b0000, pi(1,2,0,0), 32'h0, 4'b0011, 4'b0000, 32'h0};
        run_cycle(t, 1'b0, 900);
        #1;
        rst = 1'b0;
        m_ptr = 0; m_pv = '0; m_pd = '0;
        req_valid = 4'b1111;
        req_write = 4'b0101;
        req_index = pi(1,2,3,4);
        #1;
        chk_quiet("rst_inflight");
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("rst_hold");
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        t = '{4'b1111, 4'b0000, pi(1,2,3,4), 32'h0, 4'b0011, 4'b0000, 32'h0};
        run_cycle(t, 1'b1, 901);
        t = '{4'b0000, 4'b0000, pi(0,0,0,0), 32'h0, 4'b0000, 4'b0011, 32'h0000A2A1};
        run_cycle(t, 1'b1, 902);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
